// File: rtl/svga_timing_engine.sv
// Parametrised raster timing generator with a fixed-latency pixel output stage.
// Optional colour-bar source is enabled by defining SVGA_TEST_PATTERN_EN.
module svga_timing_engine #(
  parameter int H_VISIBLE    = 800,
  parameter int H_FRONT      = 40,
  parameter int H_SYNC       = 128,
  parameter int H_BACK       = 88,
  parameter int V_VISIBLE    = 600,
  parameter int V_FRONT      = 1,
  parameter int V_SYNC       = 4,
  parameter int V_BACK       = 23,
  parameter bit HSYNC_POL    = 1'b1,
  parameter bit VSYNC_POL    = 1'b1,
  parameter int X_WIDTH      = 11,
  parameter int Y_WIDTH      = 10,
  parameter int COLOR_WIDTH  = 8,
  parameter int PIPE_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   run,
  input  logic [COLOR_WIDTH-1:0] color_in,
`ifdef SVGA_TEST_PATTERN_EN
  input  logic                   test_pattern,
`endif
  output logic [X_WIDTH-1:0]     x_pixel,
  output logic [Y_WIDTH-1:0]     y_pixel,
  output logic                   visible,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [7:0]             frame_count,
  output logic [COLOR_WIDTH-1:0] color_out,
  output logic                   data_enable,
  output logic                   hsync,
  output logic                   vsync
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(H_TOTAL - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(V_TOTAL - 1);
  localparam logic [X_WIDTH:0]   X_VIS  = (X_WIDTH+1)'(H_VISIBLE);
  localparam logic [X_WIDTH:0]   HS_ON  = (X_WIDTH+1)'(H_VISIBLE + H_FRONT);
  localparam logic [X_WIDTH:0]   HS_OFF = (X_WIDTH+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [Y_WIDTH:0]   Y_VIS  = (Y_WIDTH+1)'(V_VISIBLE);
  localparam logic [Y_WIDTH:0]   VS_ON  = (Y_WIDTH+1)'(V_VISIBLE + V_FRONT);
  localparam logic [Y_WIDTH:0]   VS_OFF = (Y_WIDTH+1)'(V_VISIBLE + V_FRONT + V_SYNC);

`ifdef SVGA_TEST_PATTERN_EN
  localparam int DW = 6;
`else
  localparam int DW = 3;
`endif

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state, state_nxt;
  logic [X_WIDTH-1:0] x_nxt;
  logic [Y_WIDTH-1:0] y_nxt;
  logic               frame_end;
  logic               active, hs_req, vs_req;
  logic [DW-1:0]      req, dly;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      x_pixel     <= '0;
      y_pixel     <= '0;
      frame_count <= '0;
    end else begin
      state   <= state_nxt;
      x_pixel <= x_nxt;
      y_pixel <= y_nxt;
      if (frame_end) frame_count <= frame_count + 8'd1;
    end
  end

  // RUN only matters in IDLE and on the very last pixel of a frame.
  always_comb begin
    state_nxt = state;
    x_nxt     = x_pixel;
    y_nxt     = y_pixel;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        x_nxt = '0;
        y_nxt = '0;
        if (run) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (x_pixel == X_LAST) begin
          x_nxt = '0;
          if (y_pixel == Y_LAST) begin
            y_nxt     = '0;
            frame_end = 1'b1;
            if (!run) state_nxt = IDLE;
          end else begin
            y_nxt = y_pixel + 1'b1;
          end
        end else begin
          x_nxt = x_pixel + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign active      = (state == ACTIVE);
  assign hs_req      = active && ({1'b0, x_pixel} >= HS_ON) && ({1'b0, x_pixel} < HS_OFF);
  assign vs_req      = active && ({1'b0, y_pixel} >= VS_ON) && ({1'b0, y_pixel} < VS_OFF);
  assign visible     = active && ({1'b0, x_pixel} < X_VIS) && ({1'b0, y_pixel} < Y_VIS);
  assign line_start  = active && (x_pixel == '0);
  assign frame_start = line_start && (y_pixel == '0);

`ifdef SVGA_TEST_PATTERN_EN
  logic [X_WIDTH+9:0] x_ext;
  assign x_ext = {10'd0, x_pixel};
  assign req   = {x_ext[9:7], vs_req, hs_req, visible};
`else
  assign req = {vs_req, hs_req, visible};
`endif

  generate
    if (PIPE_LATENCY == 0) begin : g_nopipe
      assign dly = req;
    end else begin : g_pipe
      logic [DW-1:0] sr [PIPE_LATENCY];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < PIPE_LATENCY; i++) sr[i] <= '0;
        end else begin
          sr[0] <= req;
          for (int i = 1; i < PIPE_LATENCY; i++) sr[i] <= sr[i-1];
        end
      end
      assign dly = sr[PIPE_LATENCY-1];
    end
  endgenerate

  logic [COLOR_WIDTH-1:0] pix;

`ifdef SVGA_TEST_PATTERN_EN
  // Bar index repeated MSB-first across the colour word.
  function automatic logic [COLOR_WIDTH-1:0] bar_color(input logic [2:0] b);
    logic [COLOR_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < COLOR_WIDTH; i++) c[COLOR_WIDTH-1-i] = b[2 - (i % 3)];
    return c;
  endfunction
  assign pix = test_pattern ? bar_color(dly[5:3]) : color_in;
`else
  assign pix = color_in;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      color_out   <= '0;
      data_enable <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
    end else begin
      color_out   <= dly[0] ? pix : '0;
      data_enable <= dly[0];
      hsync       <= dly[1] ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= dly[2] ? VSYNC_POL : ~VSYNC_POL;
    end
  end

endmodule

// File: tb/tb_svga_timing_engine.sv
// Randomized bench for svga_timing_engine against a frame-position reference model.
// Builds with or without SVGA_TEST_PATTERN_EN.
module tb_svga_timing_engine;

`ifdef SVGA_TEST_PATTERN_EN
  localparam int HV = 700, HF = 4, HSW = 6, HB = 10;
  localparam int VV = 3,   VF = 1, VSW = 1, VB = 1;
  localparam int XW = 10,  YW = 4;
`else
  localparam int HV = 16,  HF = 4, HSW = 6, HB = 6;
  localparam int VV = 10,  VF = 1, VSW = 2, VB = 3;
  localparam int XW = 6,   YW = 5;
`endif
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam int PL = 2;
  localparam bit HSP = 1'b0;
  localparam bit VSP = 1'b1;

  logic          clk, reset_n, run, test_pattern;
  logic [7:0]    color_in;
  logic [XW-1:0] x_pixel;
  logic [YW-1:0] y_pixel;
  logic          visible, line_start, frame_start, data_enable, hsync, vsync;
  logic [7:0]    frame_count, color_out;

  svga_timing_engine #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HSYNC_POL(HSP), .VSYNC_POL(VSP), .X_WIDTH(XW), .Y_WIDTH(YW),
    .COLOR_WIDTH(8), .PIPE_LATENCY(PL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .color_in(color_in),
`ifdef SVGA_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .x_pixel(x_pixel), .y_pixel(y_pixel), .visible(visible),
    .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count),
    .color_out(color_out), .data_enable(data_enable), .hsync(hsync), .vsync(vsync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a linear position within the frame plus request history.
  bit   m_active;
  int   m_pos, m_fc, cyc;
  bit   tp_force;
  bit   h_vis [64], h_hs [64], h_vs [64], h_tp [64];
  logic [2:0] h_b [64];
  logic [7:0] h_cin [64];

  logic [XW-1:0] ex_x;
  logic [YW-1:0] ex_y;
  logic          ex_vis, ex_ls, ex_fs, ex_de, ex_hs, ex_vs;
  logic [7:0]    ex_fc, ex_col;

  function automatic logic [7:0] bar_ref(input logic [2:0] b);
    logic [23:0] rep;
    rep = {8{b}};
    return rep[23:16];
  endfunction

  task automatic model_init();
    m_active = 0;
    m_pos = 0;
    m_fc = 0;
    for (int i = 0; i < 64; i++) begin
      h_vis[i] = 0; h_hs[i] = 0; h_vs[i] = 0; h_tp[i] = 0; h_b[i] = 0; h_cin[i] = 0;
    end
  endtask

  task automatic step();
    bit r;
    int o, p, px, py;
    r = run;
    @(posedge clk); #1;
    cyc++;
    if (!m_active) begin
      if (r) begin m_active = 1; m_pos = 0; end
    end else if (m_pos == FRAME - 1) begin
      m_fc = (m_fc + 1) % 256;
      m_pos = 0;
      if (!r) m_active = 0;
    end else begin
      m_pos++;
    end
    px = m_pos % HT;
    py = m_pos / HT;
    ex_x   = XW'(px);
    ex_y   = YW'(py);
    ex_vis = m_active && px < HV && py < VV;
    ex_ls  = m_active && px == 0;
    ex_fs  = m_active && m_pos == 0;
    ex_fc  = 8'(m_fc);
    h_vis[cyc % 64] = ex_vis;
    h_hs[cyc % 64]  = m_active && px >= HV + HF && px < HV + HF + HSW;
    h_vs[cyc % 64]  = m_active && py >= VV + VF && py < VV + VF + VSW;
    h_b[cyc % 64]   = 3'((px / 128) % 8);
    o = (cyc - PL - 1) % 64;
    p = (cyc - 1) % 64;
    ex_de  = h_vis[o];
    ex_col = !h_vis[o] ? 8'd0 : (h_tp[p] ? bar_ref(h_b[o]) : h_cin[p]);
    ex_hs  = h_hs[o] ? HSP : !HSP;
    ex_vs  = h_vs[o] ? VSP : !VSP;
    color_in = 8'($urandom);
    h_cin[cyc % 64] = color_in;
`ifdef SVGA_TEST_PATTERN_EN
    test_pattern = tp_force | 1'($urandom);
`else
    test_pattern = 1'b0;
`endif
    h_tp[cyc % 64] = test_pattern;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({x_pixel, y_pixel, visible, line_start, frame_start, frame_count, color_out, data_enable, hsync, vsync}
        !== {XW'(0), YW'(0), 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, !HSP, !VSP}) begin
      errors++;
      $display("FAIL reset_values: got x=%0d y=%0d vis=%b ls=%b fs=%b fc=%0d col=%h de=%b hs=%b vs=%b, want zeros hs=%b vs=%b",
               x_pixel, y_pixel, visible, line_start, frame_start, frame_count, color_out, data_enable, hsync, vsync, !HSP, !VSP);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_init();
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({x_pixel, y_pixel, visible, line_start, frame_start, frame_count, color_out, data_enable, hsync, vsync}
          !== {ex_x, ex_y, ex_vis, ex_ls, ex_fs, ex_fc, ex_col, ex_de, ex_hs, ex_vs}) begin
        errors++;
        $display("FAIL idle_hold cyc=%0d: got %h want %h", cyc,
                 {x_pixel, y_pixel, visible, line_start, frame_start, frame_count, color_out, data_enable, hsync, vsync},
                 {ex_x, ex_y, ex_vis, ex_ls, ex_fs, ex_fc, ex_col, ex_de, ex_hs, ex_vs});
      end
    end
  endtask

  task automatic test_frames();
    run = 1'b1;
    for (int i = 0; i < 2 * FRAME + HT; i++) begin
      step();
      checks++;
      if ({x_pixel, y_pixel, visible, line_start, frame_start, frame_count}
          !== {ex_x, ex_y, ex_vis, ex_ls, ex_fs, ex_fc}) begin
        errors++;
        $display("FAIL frames_req cyc=%0d: got x=%0d y=%0d vis=%b ls=%b fs=%b fc=%0d want x=%0d y=%0d vis=%b ls=%b fs=%b fc=%0d",
                 cyc, x_pixel, y_pixel, visible, line_start, frame_start, frame_count,
                 ex_x, ex_y, ex_vis, ex_ls, ex_fs, ex_fc);
      end
      checks++;
      if ({color_out, data_enable, hsync, vsync} !== {ex_col, ex_de, ex_hs, ex_vs}) begin
        errors++;
        $display("FAIL frames_pins cyc=%0d: got col=%h de=%b hs=%b vs=%b want col=%h de=%b hs=%b vs=%b",
                 cyc, color_out, data_enable, hsync, vsync, ex_col, ex_de, ex_hs, ex_vs);
      end
    end
  endtask

  task automatic test_run_drop();
    int fc0, budget;
    bit fs_seen;
    run = 1'b1;
    budget = 0;
    while (!(m_active && m_pos == (VV / 2) * HT + 1) && budget < 2 * FRAME) begin
      step();
      budget++;
    end
    run = 1'b0;
    fc0 = m_fc;
    for (int i = 0; i < FRAME + PL + 8; i++) begin
      step();
      checks++;
      if ({x_pixel, y_pixel, visible, line_start, frame_start, frame_count, color_out, data_enable, hsync, vsync}
          !== {ex_x, ex_y, ex_vis, ex_ls, ex_fs, ex_fc, ex_col, ex_de, ex_hs, ex_vs}) begin
        errors++;
        $display("FAIL run_drop cyc=%0d: got %h want %h", cyc,
                 {x_pixel, y_pixel, visible, line_start, frame_start, frame_count, color_out, data_enable, hsync, vsync},
                 {ex_x, ex_y, ex_vis, ex_ls, ex_fs, ex_fc, ex_col, ex_de, ex_hs, ex_vs});
      end
    end
    checks++;
    if ({frame_count, data_enable, color_out, hsync, vsync} !== {8'((fc0 + 1) % 256), 1'b0, 8'd0, !HSP, !VSP}) begin
      errors++;
      $display("FAIL run_drop_idle: got fc=%0d de=%b col=%h hs=%b vs=%b want fc=%0d blanked",
               frame_count, data_enable, color_out, hsync, vsync, (fc0 + 1) % 256);
    end
    run = 1'b1;
    fs_seen = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      fs_seen |= frame_start;
    end
    checks++;
    if (fs_seen !== 1'b1) begin
      errors++;
      $display("FAIL run_restart: frame_start seen=%b want 1 within 2 cycles", fs_seen);
    end
  endtask

  task automatic test_random_run();
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ($urandom_range(0, 15) == 0) run = 1'($urandom);
      step();
      checks++;
      if ({x_pixel, y_pixel, visible, line_start, frame_start, frame_count, color_out, data_enable, hsync, vsync}
          !== {ex_x, ex_y, ex_vis, ex_ls, ex_fs, ex_fc, ex_col, ex_de, ex_hs, ex_vs}) begin
        errors++;
        $display("FAIL random_run cyc=%0d: got %h want %h", cyc,
                 {x_pixel, y_pixel, visible, line_start, frame_start, frame_count, color_out, data_enable, hsync, vsync},
                 {ex_x, ex_y, ex_vis, ex_ls, ex_fs, ex_fc, ex_col, ex_de, ex_hs, ex_vs});
      end
    end
  endtask

  task automatic test_reset_midline();
    int budget;
    run = 1'b1;
    budget = 0;
    while (!(m_active && m_pos == (VV / 2) * HT + (HV * 5) / 8) && budget < 3 * FRAME) begin
      step();
      budget++;
    end
    checks++;
    if (data_enable !== 1'b1) begin
      errors++;
      $display("FAIL midline_pre: data_enable=%b want 1 before reset", data_enable);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({x_pixel, y_pixel, visible, line_start, frame_start, frame_count, color_out, data_enable, hsync, vsync}
        !== {XW'(0), YW'(0), 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, !HSP, !VSP}) begin
      errors++;
      $display("FAIL midline_reset: got x=%0d y=%0d vis=%b fc=%0d col=%h de=%b hs=%b vs=%b want reset values",
               x_pixel, y_pixel, visible, frame_count, color_out, data_enable, hsync, vsync);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_init();
    for (int i = 0; i < HT * 2; i++) begin
      step();
      checks++;
      if ({x_pixel, y_pixel, visible, line_start, frame_start, frame_count, color_out, data_enable, hsync, vsync}
          !== {ex_x, ex_y, ex_vis, ex_ls, ex_fs, ex_fc, ex_col, ex_de, ex_hs, ex_vs}) begin
        errors++;
        $display("FAIL midline_after cyc=%0d: got %h want %h", cyc,
                 {x_pixel, y_pixel, visible, line_start, frame_start, frame_count, color_out, data_enable, hsync, vsync},
                 {ex_x, ex_y, ex_vis, ex_ls, ex_fs, ex_fc, ex_col, ex_de, ex_hs, ex_vs});
      end
    end
  endtask

`ifdef SVGA_TEST_PATTERN_EN
  task automatic test_test_pattern();
    int budget;
    run = 1'b1;
    tp_force = 1'b1;
    budget = 0;
    while (!(m_active && (m_pos % HT) == 640 && (m_pos / HT) < VV) && budget < 2 * FRAME) begin
      step();
      budget++;
    end
    repeat (3) step();
    checks++;
    if (color_out !== 8'b10110110) begin
      errors++;
      $display("FAIL test_pattern_bar5: got %b want 10110110", color_out);
    end
    tp_force = 1'b0;
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    run = 1'b0;
    color_in = 8'd0;
    test_pattern = 1'b0;
    tp_force = 1'b0;
    cyc = 1000;
    model_init();
    test_reset();
    test_frames();
    test_run_drop();
    test_random_run();
    test_reset_midline();
`ifdef SVGA_TEST_PATTERN_EN
    test_test_pattern();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/svga_timing_engine.md
# svga_timing_engine

Parametrised raster timing generator and pixel output stage: the configurable successor to the fixed 800x600 SVGA interface. It produces pixel request coordinates for the frame renderer and accepts that renderer's colour after a fixed, parameterised pipeline latency. It drives HSYNC, VSYNC, DATA_ENABLE and COLOR_OUT, all aligned at the pins. Frames start and stop cleanly under a RUN control, so reconfiguration or clock switching never emits partial frames.

## Interface
- H_VISIBLE, 800, visible pixels per line
- H_FRONT, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BACK, 88, horizontal back porch (pixels)
- V_VISIBLE, 600, visible lines
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BACK, 23, vertical back porch (lines)
- HSYNC_POL, 1, active level of HSYNC
- VSYNC_POL, 1, active level of VSYNC
- X_WIDTH, 11, X counter width; must hold H total minus 1
- Y_WIDTH, 10, Y counter width; must hold V total minus 1
- COLOR_WIDTH, 8, colour bits (opaque value)
- PIPE_LATENCY, 2, cycles from coordinate request to valid COLOR_IN (0..15)

Ports:
- CLK  in  1  pixel clock
- RESET_N  in  1  asynchronous, active-low reset
- RUN  in  1  1 = generate frames; sampled at frame boundaries only
- COLOR_IN  in  COLOR_WIDTH  renderer colour for coordinate issued PIPE_LATENCY cycles earlier
- TEST_PATTERN  in  1  select built-in colour bars (present only with macro)
- X_PIXEL  out  X_WIDTH  request x coordinate
- Y_PIXEL  out  Y_WIDTH  request y coordinate
- VISIBLE  out  1  request coordinate is inside the visible area
- LINE_START  out  1  one-cycle pulse when ACTIVE and X_PIXEL==0
- FRAME_START  out  1  one-cycle pulse when ACTIVE and X_PIXEL==0, Y_PIXEL==0
- FRAME_COUNT  out  8  completed-frame counter, wraps 255->0
- COLOR_OUT  out  COLOR_WIDTH  pin colour, 0 when blanked
- DATA_ENABLE  out  1  pin-aligned visible flag
- HSYNC, VSYNC  out  1  pin-aligned syncs

## Operation
- H_TOTAL = sum of H_* parameters; V_TOTAL = sum of V_* parameters. Visible region starts at (0,0); front porch, sync and back porch follow in that order.
- States:
  - IDLE: counters held at (0,0); VISIBLE, LINE_START and FRAME_START are 0.
  - ACTIVE: X increments every cycle and wraps H_TOTAL-1 -> 0. Y increments when X==H_TOTAL-1 and wraps V_TOTAL-1 -> 0.
- IDLE -> ACTIVE when RUN=1. The first ACTIVE cycle presents (0,0) with FRAME_START=1.
- ACTIVE -> IDLE only at the last pixel of the last line (X=H_TOTAL-1, Y=V_TOTAL-1) with RUN=0.
  - Deasserting RUN mid-frame completes the current frame.
  - RUN=1 at that point continues directly into the next frame with no gap.
- FRAME_COUNT increments at every frame end (last pixel of last line in ACTIVE), whatever the RUN value.
- Request-time flags:
  - hs_req = X in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC)
  - vs_req = Y in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC)
  - VISIBLE = ACTIVE and X<H_VISIBLE and Y<V_VISIBLE
- In IDLE, hs_req, vs_req and VISIBLE are forced inactive.
- hs_req, vs_req and VISIBLE pass through a PIPE_LATENCY-deep shift register, then one output register. At the output register:
  - COLOR_OUT = delayed VISIBLE ? COLOR_IN : 0
  - DATA_ENABLE = delayed VISIBLE
  - HSYNC = delayed hs_req ? HSYNC_POL : !HSYNC_POL (VSYNC likewise)

## Timing
- Coordinate issued at cycle t appears at the pins (COLOR_OUT, DATA_ENABLE, HSYNC, VSYNC) at cycle t+PIPE_LATENCY+1. With PIPE_LATENCY=0 this is one-cycle registered behaviour.
- COLOR_IN is sampled at t+PIPE_LATENCY.
- Reset (asynchronous assert, synchronous release to logic):
  - state=IDLE, X=0, Y=0, FRAME_COUNT=0, shift register cleared to inactive
  - COLOR_OUT=0, DATA_ENABLE=0, HSYNC=!HSYNC_POL, VSYNC=!VSYNC_POL
  - VISIBLE, LINE_START, FRAME_START all 0
- Reset mid-frame aborts immediately. No partial-frame flush is required.
- After ACTIVE -> IDLE, the pipeline drains PIPE_LATENCY+1 cycles of inactive values. The pins then stay blanked with syncs inactive.

## Configuration
- SVGA_TEST_PATTERN_EN defined:
  - The TEST_PATTERN port exists.
  - When TEST_PATTERN=1 (sampled at the output register), visible pixels take the colour-bar value instead of COLOR_IN.
  - Bar value: bar index b = request X[9:7], carried through the same delay line as VISIBLE. The colour is b repeated MSB-first to COLOR_WIDTH bits; for b=3'b101 at width 8 this is 8'b10110110.
  - Blanked pixels remain 0.
- Not defined: no TEST_PATTERN port, no delay-line bits for b; COLOR_OUT always follows COLOR_IN.

## Test plan
- Reset, RUN=1, defaults: FRAME_START asserts the cycle after leaving IDLE. LINE_START pulses every 1056 cycles. FRAME_START pulses every 1056*628=663168 cycles.
- X=840 issued at cycle t: HSYNC=1 from t+3 through t+130, 0 at t+131. VSYNC=1 exactly for request lines 601-604.
- COLOR_IN driven as a function of the coordinate issued 2 cycles earlier: COLOR_OUT equals the expected value for all visible pixels. COLOR_OUT=0 and DATA_ENABLE=0 at request X>=800 or Y>=600.
- RUN dropped at Y=300: the frame completes, then the block enters IDLE and pins are blanked. FRAME_COUNT increments once. RUN re-raised: the next FRAME_START follows within 2 cycles.
- RESET_N pulsed low mid-line at X=500, Y=100: all outputs take reset values asynchronously. HSYNC_POL=0 build: HSYNC idles at 1.
- With SVGA_TEST_PATTERN_EN, TEST_PATTERN=1: request X=640 (b=5) yields COLOR_OUT=8'b10110110 three cycles later.
